// File: rtl/frame_reader_pkg.sv
// Types and constants shared by frame_reader and its FIFO. The width macros are
// owned by global.v; the fallbacks below only apply when it has not been read.
`ifndef W_PW
`define W_PW 9
`endif
`ifndef W_PH
`define W_PH 8
`endif
`ifndef W_AFRAMEBUF
`define W_AFRAMEBUF 13
`endif
`ifndef W1
`define W1 7
`endif
`ifndef FRAME_BUF_LINE
`define FRAME_BUF_LINE 64
`endif

package frame_reader_pkg;

  localparam int ADDR_W = `W_AFRAMEBUF + 1;
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(`FRAME_BUF_LINE);
  localparam logic [1:0] FIFO_DEPTH = 2'd2;

  typedef struct packed {
    logic [`W1:0] data;
    logic         sof;
    logic         eol;
    logic         eof;
  } pix_t;

  // A new read may only be issued if its data is guaranteed a FIFO slot even
  // when nothing is popped while it is in flight.
  function automatic logic has_credit(input logic [1:0] count,
                                      input logic       pop,
                                      input logic       in_flight);
    logic [2:0] used;
    used = {1'b0, count} - {2'b00, pop} + {2'b00, in_flight};
    return used < 3'd2;
  endfunction

endpackage

// File: rtl/frame_reader_fifo2.sv
// Two-entry register FIFO of pixels plus markers; the head entry drives the
// output stream directly so it stays stable while the consumer stalls.
module frame_reader_fifo2
  import frame_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  pix_t       din,
  output pix_t       head,
  output logic [1:0] count
);

  pix_t tail;
  logic do_pop;

  assign do_pop = pop && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b11: begin
          if (count == FIFO_DEPTH) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            head <= din;
          end else if (count == 2'd1) begin
            tail <= din;
          end
          if (count != FIFO_DEPTH) begin
            count <= count + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Reads a captured frame out of the frame buffer in raster order as a marked
// valid/ready stream. Define FRAME_READER_MIRROR_EN for a horizontally mirrored read.
module frame_reader
  import frame_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`W_PW:0]        pic_width,
  input  logic [`W_PH:0]        pic_height,
  input  logic                  frame_ready,
  output logic                  cena_frame_buf,
  output logic [`W_AFRAMEBUF:0] aa_frame_buf,
  input  logic [`W1:0]          qa_frame_buf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [`W1:0]          out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [`W_PW:0]        width_q;
  logic [`W_PW:0]        x;
  logic [`W_PW:0]        x_term;
  logic [`W_PH:0]        height_q;
  logic [`W_PH:0]        y;
  logic [`W_AFRAMEBUF:0] line_base;
  logic                  pend;
  logic                  pend_sof;
  logic                  pend_eol;
  logic                  pend_eof;
  logic                  pop;
  logic                  issue;
  logic                  last_x;
  logic                  last_y;
  pix_t                  fifo_in;
  pix_t                  fifo_head;
  logic [1:0]            fifo_count;

  assign pop    = out_valid && out_ready;
  assign last_x = (x == width_q - 1'b1);
  assign last_y = (y == height_q - 1'b1);
  assign issue  = (state == READ) && has_credit(fifo_count, pop, pend);

`ifdef FRAME_READER_MIRROR_EN
  assign x_term = width_q - 1'b1 - x;
`else
  assign x_term = x;
`endif

  // The read port is driven straight from the credit decision so a stall
  // stops reads in the same cycle it is seen.
  assign cena_frame_buf = ~issue;
  assign aa_frame_buf   = line_base + ADDR_W'(x_term);
  assign overrun        = frame_ready && busy;

  assign fifo_in = {qa_frame_buf, pend_sof, pend_eol, pend_eof};

  frame_reader_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pend),
    .pop   (pop),
    .din   (fifo_in),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_head.data;
  assign out_sof   = fifo_head.sof;
  assign out_eol   = fifo_head.eol;
  assign out_eof   = fifo_head.eof;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      width_q   <= '0;
      height_q  <= '0;
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      pend      <= 1'b0;
      pend_sof  <= 1'b0;
      pend_eol  <= 1'b0;
      pend_eof  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      pend <= issue;
      if (issue) begin
        pend_sof <= (x == '0) && (y == '0);
        pend_eol <= last_x;
        pend_eof <= last_x && last_y;
      end
      case (state)
        IDLE: begin
          if (frame_ready) begin
            if (pic_width != '0 && pic_height != '0) begin
              width_q   <= pic_width;
              height_q  <= pic_height;
              x         <= '0;
              y         <= '0;
              line_base <= '0;
              busy      <= 1'b1;
              state     <= READ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            if (last_x) begin
              x <= '0;
              if (last_y) begin
                state <= DRAIN;
              end else begin
                y         <= y + 1'b1;
                line_base <= line_base + LINE_STEP;
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop && out_eof) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader: a raster-order model of every frame
// predicts read addresses and output beats, checked each cycle by one monitor.
module tb_frame_reader;

  localparam int L         = `FRAME_BUF_LINE;
  localparam int MEM_WORDS = 1 << (`W_AFRAMEBUF + 1);
  localparam int PW        = `W_PW + 1;
  localparam int PH        = `W_PH + 1;

  typedef struct packed {
    logic [`W1:0] data;
    logic         sof;
    logic         eol;
    logic         eof;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [`W_PW:0]        pic_width = '0;
  logic [`W_PH:0]        pic_height = '0;
  logic                  frame_ready = 1'b0;
  logic                  cena_frame_buf;
  logic [`W_AFRAMEBUF:0] aa_frame_buf;
  logic [`W1:0]          qa_frame_buf = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [`W1:0]          out_data;
  logic                  out_sof;
  logic                  out_eol;
  logic                  out_eof;
  logic                  busy;
  logic                  done;
  logic                  overrun;

  frame_reader dut (
    .clk            (clk),
    .rst            (rst),
    .pic_width      (pic_width),
    .pic_height     (pic_height),
    .frame_ready    (frame_ready),
    .cena_frame_buf (cena_frame_buf),
    .aa_frame_buf   (aa_frame_buf),
    .qa_frame_buf   (qa_frame_buf),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sof        (out_sof),
    .out_eol        (out_eol),
    .out_eof        (out_eof),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  logic [`W1:0] mem [0:MEM_WORDS-1];

  always @(posedge clk) begin
    if (!cena_frame_buf) qa_frame_buf <= mem[aa_frame_buf];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    checks = 0;
  int    errors = 0;
  int    exp_addr[$];
  beat_t exp_beats[$];
  int    aa_log[$];
  int    ready_mode = 0;
  logic [3:0] toggle_pat = 4'b1001;

  int start_cyc = 0, frame_base = 0, eol0 = 0, eof0 = 0;
  int beat_cnt = 0, eol_cnt = 0, eof_cnt = 0, done_cnt = 0, ovr_cnt = 0;
  int first_cyc = 0, first_flags = 0, eof_cyc = 0, done_cyc = 0, ovr_cyc = 0;
  int busy_rise = 0, busy_fall = 0, exp_done_cyc = -1;
  bit prev_stall = 1'b0, prev_busy = 1'b0;
  beat_t prev_beat;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic fillMem();
    for (int i = 0; i < 5 * L; i++) mem[i] = `W1'($urandom);
  endtask

  task automatic applyStimulus(input int w, input int h);
    @(posedge clk);
    #1;
    pic_width   = PW'(w);
    pic_height  = PH'(h);
    frame_ready = 1'b1;
    start_cyc   = cyc;
    frame_base  = beat_cnt;
    eol0        = eol_cnt;
    eof0        = eof_cnt;
    aa_log.delete();
    if (w != 0 && h != 0) begin
      for (int yy = 0; yy < h; yy++) begin
        for (int xx = 0; xx < w; xx++) begin
          int    addr;
          beat_t b;
`ifdef FRAME_READER_MIRROR_EN
          addr = yy * L + (w - 1 - xx);
`else
          addr = yy * L + xx;
`endif
          exp_addr.push_back(addr);
          b.data = mem[addr];
          b.sof  = (xx == 0) && (yy == 0);
          b.eol  = (xx == w - 1);
          b.eof  = (xx == w - 1) && (yy == h - 1);
          exp_beats.push_back(b);
        end
      end
    end else begin
      exp_done_cyc = cyc + 1;
    end
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == n0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    checkOutput("done_pulses", done_cnt - n0, 1);
    checkOutput("beats_outstanding", exp_beats.size(), 0);
    checkOutput("reads_outstanding", exp_addr.size(), 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cena"}, int'(cena_frame_buf), 1);
    checkOutput({tag, "_aa"}, int'(aa_frame_buf), 0);
    checkOutput({tag, "_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_data_markers"}, int'({out_data, out_sof, out_eol, out_eof}), 0);
    checkOutput({tag, "_busy_done_overrun"}, int'({busy, done, overrun}), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = toggle_pat[(cyc - start_cyc) % 4];
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Compare process: every read and every transfer is checked against the model.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      beat_t cur;
      cur = {out_data, out_sof, out_eol, out_eof};
      if (!cena_frame_buf) begin
        aa_log.push_back(int'(aa_frame_buf));
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_read: got address %0d, expected no read", aa_frame_buf);
        end else begin
          checkOutput("read_addr", int'(aa_frame_buf), exp_addr.pop_front());
        end
      end
      if (prev_stall) begin
        checkOutput("stall_hold", int'({out_valid, cur}), int'({1'b1, prev_beat}));
        checkOutput("fifo_count_le2", int'(dut.u_fifo.count <= 2'd2), 1);
      end
      if (out_valid && out_ready) begin
        if (beat_cnt == frame_base) begin
          first_cyc   = cyc;
          first_flags = int'({out_sof, out_eol, out_eof});
        end
        beat_cnt++;
        if (out_eol) eol_cnt++;
        if (out_eof) begin
          eof_cnt++;
          eof_cyc      = cyc;
          exp_done_cyc = cyc + 1;
        end
        if (exp_beats.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got data %0d, expected no beat", out_data);
        end else begin
          beat_t e;
          e = exp_beats.pop_front();
          checkOutput("beat_data", int'(out_data), int'(e.data));
          checkOutput("beat_markers", int'({out_sof, out_eol, out_eof}), int'({e.sof, e.eol, e.eof}));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = cur;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        checkOutput("done_timing", cyc, exp_done_cyc);
      end
      if (overrun) begin
        ovr_cnt++;
        ovr_cyc = cyc;
      end
      if (busy && !prev_busy) busy_rise = cyc;
      if (!busy && prev_busy) busy_fall = cyc;
      prev_busy = busy;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0;
    int d0;
    int o0;
    fillMem();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("por");

    // 4x3 with the consumer always ready: pinned cycle numbers and addresses.
    ready_mode = 0;
    applyStimulus(4, 3);
    waitDone(200);
    checkOutput("first_beat_cycle", first_cyc - start_cyc, 3);
    checkOutput("first_beat_flags", first_flags, 4);
    checkOutput("eof_cycle", eof_cyc - start_cyc, 14);
    checkOutput("done_cycle", done_cyc - start_cyc, 15);
    checkOutput("busy_rise", busy_rise - start_cyc, 1);
    checkOutput("busy_fall", busy_fall - start_cyc, 15);
    checkOutput("beats_4x3", beat_cnt - frame_base, 12);
    checkOutput("eol_4x3", eol_cnt - eol0, 3);
    checkOutput("eof_4x3", eof_cnt - eof0, 1);
    checkOutput("aa_count_4x3", aa_log.size(), 12);
`ifndef FRAME_READER_MIRROR_EN
    for (int i = 0; i < 12 && i < aa_log.size(); i++) begin
      checkOutput("aa_seq_4x3", aa_log[i], (i / 4) * L + (i % 4));
    end
`endif

    // 4x3 with out_ready cycling 1,0,0,1.
    ready_mode = 1;
    applyStimulus(4, 3);
    waitDone(400);
    checkOutput("beats_toggle", beat_cnt - frame_base, 12);

    // Single-column frames.
    ready_mode = 0;
    applyStimulus(1, 2);
    waitDone(100);
    checkOutput("beats_1x2", beat_cnt - frame_base, 2);
    checkOutput("eol_1x2", eol_cnt - eol0, 2);
    checkOutput("eof_1x2", eof_cnt - eof0, 1);
    checkOutput("first_flags_1x2", first_flags, 6);
    applyStimulus(1, 1);
    waitDone(100);
    checkOutput("beats_1x1", beat_cnt - frame_base, 1);
    checkOutput("first_flags_1x1", first_flags, 7);

    // Zero dimensions: no reads, done the next cycle.
    applyStimulus(0, 3);
    waitDone(50);
    checkOutput("zero_w_reads", aa_log.size(), 0);
    applyStimulus(4, 0);
    waitDone(50);
    checkOutput("zero_h_beats", beat_cnt - frame_base, 0);

    // A second frame_ready in cycle 5 is flagged and otherwise ignored.
    o0 = ovr_cnt;
    applyStimulus(4, 3);
    repeat (4) @(posedge clk);
    #1;
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    waitDone(200);
    checkOutput("overrun_pulses", ovr_cnt - o0, 1);
    checkOutput("overrun_cycle", ovr_cyc - start_cyc, 5);
    checkOutput("beats_overrun", beat_cnt - frame_base, 12);

    // Reset while beat 6 is presented abandons the frame without done.
    d0 = done_cnt;
    applyStimulus(4, 3);
    for (int i = 0; i < 60 && beat_cnt - frame_base < 6; i++) @(posedge clk);
    checkOutput("beats_before_reset", beat_cnt - frame_base, 6);
    #1;
    rst = 1'b1;
    exp_beats.delete();
    exp_addr.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("mid_reset");
    repeat (20) @(posedge clk);
    checkOutput("abandoned_done", done_cnt - d0, 0);
    applyStimulus(4, 3);
    waitDone(200);
    checkOutput("restart_first_flags", first_flags, 4);
`ifdef FRAME_READER_MIRROR_EN
    checkOutput("restart_first_addr", aa_log[0], 3);
`else
    checkOutput("restart_first_addr", aa_log[0], 0);
`endif

`ifdef FRAME_READER_MIRROR_EN
    applyStimulus(4, 1);
    waitDone(100);
    checkOutput("mirror_aa_count", aa_log.size(), 4);
    for (int i = 0; i < 4 && i < aa_log.size(); i++) begin
      checkOutput("mirror_aa_seq", aa_log[i], 3 - i);
    end
    checkOutput("mirror_first_flags", first_flags, 4);
`endif

    // Randomized frames, contents and back-pressure.
    for (int f = 0; f < 8; f++) begin
      int w;
      int h;
      b0 = beat_cnt;
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 4);
      ready_mode = $urandom_range(0, 2);
      fillMem();
      applyStimulus(w, h);
      waitDone(w * h * 12 + 40);
      checkOutput("beats_random", beat_cnt - b0, w * h);
    end

    checkOutput("overrun_total", ovr_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
